and_unit_scheduler: RTL and testbench

Round-robin scheduler that shares one registered AND unit between NREQ requesters. It accepts one operand pair at a time over per-requester valid/ready handshakes and drives the pair onto the shared unit. It waits out the unit's fixed latency, captures the result, and returns it with the winning requester's ID on a single valid/ready response port. It sits between client blocks and the single shared `and_gate`-style datapath instance.

---
 rtl/and_unit_scheduler.sv | 161 ++++++++++++++++
 tb/tb_and_unit_scheduler.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/and_unit_scheduler.sv
// Round-robin front end for one shared, registered AND unit: grants one requester
// at a time, waits out the unit latency, and returns the result with the owner's ID.
module and_unit_scheduler #(
    parameter int NREQ     = 4,
    parameter int W        = 8,
    parameter int UNIT_LAT = 1,
    parameter int IDW      = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_val,
    output logic [NREQ-1:0]   req_rdy,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              resp_val,
    input  logic              resp_rdy,
    output logic [IDW-1:0]    resp_id,
    output logic [W-1:0]      resp_y,
    output logic [W-1:0]      unit_a,
    output logic [W-1:0]      unit_b,
    input  logic [W-1:0]      unit_y,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never waits on ready, and an offered payload holds until taken.

    localparam int CNTW = $clog2(UNIT_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]      unit_a_q, unit_a_d;
    logic [W-1:0]      unit_b_q, unit_b_d;
    logic [W-1:0]      resp_y_q, resp_y_d;
    logic [IDW-1:0]    resp_id_q, resp_id_d;

    logic              grant_found;
    logic [IDW-1:0]    grant_id;
    logic [IDW-1:0]    ptr_next;
    logic [NREQ-1:0]   grant_onehot;
    logic [W-1:0]      sel_a;
    logic [W-1:0]      sel_b;

    // Lowest requesting index overall, then overridden by the lowest at or above
    // the pointer; together this is the circular search starting at rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_val[i]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_val[i] && (i >= int'(rr_ptr_q))) begin
                grant_id = IDW'(i);
            end
        end
    end

    always_comb begin
        sel_a        = '0;
        sel_b        = '0;
        grant_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_onehot[i] = (grant_id == IDW'(i));
            if (grant_id == IDW'(i)) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

    assign ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        unit_a_d  = unit_a_q;
        unit_b_d  = unit_b_q;
        resp_y_d  = resp_y_q;
        resp_id_d = resp_id_q;
        req_rdy   = '0;
        unit_case: case (state_q)
            IDLE: begin
                // Reset also masks the grant so req_rdy reads zero while held in reset.
                if (grant_found && reset) begin
                    req_rdy   = grant_onehot;
                    unit_a_d  = sel_a;
                    unit_b_d  = sel_b;
                    resp_id_d = grant_id;
                    cnt_d     = CNTW'(UNIT_LAT);
                    rr_ptr_d  = ptr_next;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNTW'(1);
                end else begin
                    resp_y_d = unit_y;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (resp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            unit_a_q  <= '0;
            unit_b_q  <= '0;
            resp_y_q  <= '0;
            resp_id_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            unit_a_q  <= unit_a_d;
            unit_b_q  <= unit_b_d;
            resp_y_q  <= resp_y_d;
            resp_id_q <= resp_id_d;
        end
    end

    assign resp_val  = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign resp_id   = resp_id_q;
    assign resp_y    = resp_y_q;
    assign unit_a    = unit_a_q;
    assign unit_b    = unit_b_q;
    assign dbg_state = state_q;

    a_rdy_onehot0: assert property (@(posedge clk) disable iff (!reset) $onehot0(req_rdy));
    a_rdy_idle_only: assert property (@(posedge clk) disable iff (!reset) busy |-> (req_rdy == '0));
    a_operands_hold: assert property (@(posedge clk) disable iff (!reset)
        (busy && $past(busy)) |-> ($stable(unit_a) && $stable(unit_b)));
    a_resp_hold: assert property (@(posedge clk) disable iff (!reset)
        (resp_val && !resp_rdy) |=> (resp_val && $stable(resp_y) && $stable(resp_id)));

endmodule

// File: tb/tb_and_unit_scheduler.sv
// Bench for and_unit_scheduler: directed scenarios plus a randomized run, all checked
// against a transaction-level model (circular search, latency timeline, result queue).
module tb_and_unit_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req_val = '0;
    logic [NREQ-1:0]   req_rdy;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic              resp_val;
    logic              resp_rdy = 1'b1;
    logic [IDW-1:0]    resp_id;
    logic [W-1:0]      resp_y;
    logic [W-1:0]      unit_a, unit_b, unit_y;
    logic              busy;
    logic [1:0]        dbg_state;

    logic [NREQ-1:0]   req_val3 = '0;
    logic [NREQ-1:0]   req_rdy3;
    logic [NREQ*W-1:0] req_a3 = '0;
    logic [NREQ*W-1:0] req_b3 = '0;
    logic              resp_val3;
    logic              resp_rdy3 = 1'b1;
    logic [IDW-1:0]    resp_id3;
    logic [W-1:0]      resp_y3;
    logic [W-1:0]      unit_a3, unit_b3, unit_y3;
    logic              busy3;
    logic [1:0]        dbg_state3;

    and_unit_scheduler #(.NREQ(NREQ), .W(W), .UNIT_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy),
        .req_a(req_a), .req_b(req_b), .resp_val(resp_val), .resp_rdy(resp_rdy),
        .resp_id(resp_id), .resp_y(resp_y), .unit_a(unit_a), .unit_b(unit_b),
        .unit_y(unit_y), .busy(busy), .dbg_state(dbg_state)
    );

    and_unit_scheduler #(.NREQ(NREQ), .W(W), .UNIT_LAT(LAT3)) dut3 (
        .clk(clk), .reset(reset), .req_val(req_val3), .req_rdy(req_rdy3),
        .req_a(req_a3), .req_b(req_b3), .resp_val(resp_val3), .resp_rdy(resp_rdy3),
        .resp_id(resp_id3), .resp_y(resp_y3), .unit_a(unit_a3), .unit_b(unit_b3),
        .unit_y(unit_y3), .busy(busy3), .dbg_state(dbg_state3)
    );

    // Shared AND units: one register stage each.
    always_ff @(posedge clk) unit_y <= unit_a & unit_b;
    always_ff @(posedge clk) unit_y3 <= unit_a3 & unit_b3;

    int vectors = 0;
    int miscompares = 0;
    int m_ptr = 0;
    logic [IDW+W-1:0] exp_q[$];
    logic [W-1:0] op_a[NREQ];
    logic [W-1:0] op_b[NREQ];

    function automatic int rr_pick(int ptr, logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            int idx = (ptr + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(int g);
        logic [NREQ-1:0] r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
        end
    endtask

    task automatic model_accept(input int g);
        exp_q.push_back({IDW'(g), op_a[g] & op_b[g]});
        m_ptr = (g + 1) % NREQ;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        m_ptr = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [IDW+W-1:0] got;
        reset = 1'b0;
        req_val = 4'b1111;
        #3;
        got = {resp_id, resp_y};
        vectors++;
        if (req_rdy !== 4'b0000) begin miscompares++; $display("FAIL reset_rdy: got %b want 0000", req_rdy); end
        vectors++;
        if (resp_val !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_flags: val=%b busy=%b want 0 0", resp_val, busy); end
        vectors++;
        if (got !== '0 || unit_a !== '0 || unit_b !== '0) begin
            miscompares++; $display("FAIL reset_data: id_y=%h ua=%h ub=%h want 0", got, unit_a, unit_b);
        end
        req_val = '0;
        tick();
        reset = 1'b1;
        tick();
        vectors++;
        if (req_rdy !== 4'b0000 || busy !== 1'b0) begin miscompares++; $display("FAIL idle_no_req: rdy=%b busy=%b want 0000 0", req_rdy, busy); end
        m_ptr = 0;
    endtask

    task automatic test_single_op();
        op_a[0] = 8'hF0;
        op_b[0] = 8'h3C;
        load_ops();
        resp_rdy = 1'b1;
        req_val = 4'b0001;
        #1;
        vectors++;
        if (req_rdy !== 4'b0001) begin miscompares++; $display("FAIL single_rdy: got %b want 0001", req_rdy); end
        tick();
        req_val = '0;
        m_ptr = 1;
        vectors++;
        if (busy !== 1'b1 || resp_val !== 1'b0) begin miscompares++; $display("FAIL single_exec1: busy=%b val=%b want 1 0", busy, resp_val); end
        tick();
        vectors++;
        if (busy !== 1'b1 || resp_val !== 1'b0 || unit_a !== 8'hF0 || unit_b !== 8'h3C) begin
            miscompares++; $display("FAIL single_exec2: busy=%b val=%b ua=%h ub=%h want 1 0 f0 3c", busy, resp_val, unit_a, unit_b);
        end
        tick();
        vectors++;
        if (resp_val !== 1'b1 || resp_y !== 8'h30 || resp_id !== 2'd0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL single_resp: val=%b y=%h id=%0d busy=%b want 1 30 0 1", resp_val, resp_y, resp_id, busy);
        end
        tick();
        vectors++;
        if (resp_val !== 1'b0 || busy !== 1'b0 || unit_a !== 8'hF0) begin
            miscompares++; $display("FAIL single_done: val=%b busy=%b ua=%h want 0 0 f0", resp_val, busy, unit_a);
        end
    endtask

    task automatic test_round_robin();
        logic [IDW+W-1:0] exp, got;
        int g;
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = {4'(i), 4'($urandom_range(0, 15))} | 8'h0F;
            op_b[i] = 8'($urandom_range(0, 255));
        end
        load_ops();
        req_val = 4'b1111;
        resp_rdy = 1'b1;
        for (int n = 0; n < 6; n++) begin
            #1;
            g = rr_pick(m_ptr, req_val);
            vectors++;
            if (req_rdy !== onehot(n % NREQ)) begin miscompares++; $display("FAIL rr_grant%0d: got %b want %b", n, req_rdy, onehot(n % NREQ)); end
            model_accept(g);
            tick(); tick(); tick();
            exp = exp_q.pop_front();
            got = {resp_id, resp_y};
            vectors++;
            if (resp_val !== 1'b1 || got !== exp) begin miscompares++; $display("FAIL rr_resp%0d: val=%b id_y=%h want 1 %h", n, resp_val, got, exp); end
            tick();
        end
    endtask

    task automatic test_wrap();
        logic [NREQ-1:0] vals[3] = '{4'b0100, 4'b0011, 4'b0011};
        int want[3] = '{2, 0, 1};
        logic [IDW+W-1:0] exp, got;
        int g;
        for (int n = 0; n < 3; n++) begin
            req_val = vals[n];
            #1;
            g = rr_pick(m_ptr, req_val);
            vectors++;
            if (req_rdy !== onehot(want[n]) || g != want[n]) begin miscompares++; $display("FAIL wrap_grant%0d: got %b want %b", n, req_rdy, onehot(want[n])); end
            model_accept(g);
            tick();
            op_a[g] = 8'($urandom_range(0, 255));
            op_b[g] = 8'($urandom_range(0, 255));
            load_ops();
            tick(); tick();
            exp = exp_q.pop_front();
            got = {resp_id, resp_y};
            vectors++;
            if (resp_val !== 1'b1 || got !== exp) begin miscompares++; $display("FAIL wrap_resp%0d: val=%b id_y=%h want 1 %h", n, resp_val, got, exp); end
            tick();
        end
    endtask

    task automatic test_back_pressure();
        logic [IDW+W-1:0] exp, got;
        int g;
        req_val = 4'b1111;
        resp_rdy = 1'b0;
        #1;
        g = rr_pick(m_ptr, req_val);
        vectors++;
        if (req_rdy !== onehot(g)) begin miscompares++; $display("FAIL bp_grant: got %b want %b", req_rdy, onehot(g)); end
        model_accept(g);
        tick(); tick(); tick();
        exp = exp_q[0];
        for (int k = 0; k < 6; k++) begin
            got = {resp_id, resp_y};
            vectors++;
            if (resp_val !== 1'b1 || got !== exp || req_rdy !== 4'b0000) begin
                miscompares++; $display("FAIL bp_hold%0d: val=%b id_y=%h rdy=%b want 1 %h 0000", k, resp_val, got, req_rdy, exp);
            end
            tick();
        end
        resp_rdy = 1'b1;
        void'(exp_q.pop_front());
        #1;
        vectors++;
        if (resp_val !== 1'b1 || req_rdy !== 4'b0000) begin miscompares++; $display("FAIL bp_release: val=%b rdy=%b want 1 0000", resp_val, req_rdy); end
        tick();
        g = rr_pick(m_ptr, req_val);
        vectors++;
        if (resp_val !== 1'b0 || req_rdy !== onehot(g)) begin miscompares++; $display("FAIL bp_next: val=%b rdy=%b want 0 %b", resp_val, req_rdy, onehot(g)); end
        model_accept(g);
        tick(); tick(); tick();
        exp = exp_q.pop_front();
        got = {resp_id, resp_y};
        vectors++;
        if (resp_val !== 1'b1 || got !== exp) begin miscompares++; $display("FAIL bp_resp2: val=%b id_y=%h want 1 %h", resp_val, got, exp); end
        tick();
    endtask

    task automatic test_latency();
        req_a3[W-1:0] = 8'hFF;
        req_b3[W-1:0] = 8'hA5;
        resp_rdy3 = 1'b1;
        req_val3 = 4'b0001;
        #1;
        vectors++;
        if (req_rdy3 !== 4'b0001) begin miscompares++; $display("FAIL lat_grant: got %b want 0001", req_rdy3); end
        tick();
        req_val3 = '0;
        req_a3 = '0;
        req_b3 = '0;
        for (int k = 1; k <= 4; k++) begin
            vectors++;
            if (resp_val3 !== 1'b0 || busy3 !== 1'b1 || unit_a3 !== 8'hFF || unit_b3 !== 8'hA5) begin
                miscompares++; $display("FAIL lat_exec%0d: val=%b busy=%b ua=%h ub=%h want 0 1 ff a5", k, resp_val3, busy3, unit_a3, unit_b3);
            end
            tick();
        end
        vectors++;
        if (resp_val3 !== 1'b1 || resp_y3 !== 8'hA5 || resp_id3 !== 2'd0) begin
            miscompares++; $display("FAIL lat_resp: val=%b y=%h id=%0d want 1 a5 0", resp_val3, resp_y3, resp_id3);
        end
        tick();
        vectors++;
        if (resp_val3 !== 1'b0 || busy3 !== 1'b0) begin miscompares++; $display("FAIL lat_done: val=%b busy=%b want 0 0", resp_val3, busy3); end
    endtask

    task automatic test_reset_mid_op();
        logic [IDW+W-1:0] exp, got;
        int g;
        req_val = 4'b1111;
        resp_rdy = 1'b1;
        #1;
        g = rr_pick(m_ptr, req_val);
        model_accept(g);
        tick();
        req_val = 4'b1010;
        #2;
        reset = 1'b0;
        #1;
        exp_q.delete();
        m_ptr = 0;
        vectors++;
        if (resp_val !== 1'b0 || busy !== 1'b0 || req_rdy !== 4'b0000) begin
            miscompares++; $display("FAIL rst_mid: val=%b busy=%b rdy=%b want 0 0 0000", resp_val, busy, req_rdy);
        end
        tick();
        vectors++;
        if (resp_val !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_hold: val=%b busy=%b want 0 0", resp_val, busy); end
        #2;
        reset = 1'b1;
        #1;
        g = rr_pick(m_ptr, req_val);
        vectors++;
        if (req_rdy !== onehot(g) || g != 1) begin miscompares++; $display("FAIL rst_first_grant: got %b want 0010", req_rdy); end
        model_accept(g);
        tick();
        req_val = '0;
        tick();
        vectors++;
        if (resp_val !== 1'b0) begin miscompares++; $display("FAIL rst_stale_resp: val=%b want 0", resp_val); end
        tick();
        exp = exp_q.pop_front();
        got = {resp_id, resp_y};
        vectors++;
        if (resp_val !== 1'b1 || got !== exp) begin miscompares++; $display("FAIL rst_resp: val=%b id_y=%h want 1 %h", resp_val, got, exp); end
        tick();
    endtask

    // Transaction timeline: an accept in cycle c presents its result from c+LAT+2
    // until it is taken; the scheduler is free again the cycle after the take.
    task automatic test_random();
        logic [IDW+W-1:0] exp, got;
        logic [NREQ-1:0] exp_rdy;
        logic exp_val;
        bit m_busy = 0;
        int m_due = 0;
        int g;
        for (int c = 0; c < 400; c++) begin
            req_val = NREQ'($urandom_range(0, 15));
            resp_rdy = ($urandom_range(0, 3) != 0);
            load_ops();
            #1;
            g = rr_pick(m_ptr, req_val);
            exp_rdy = m_busy ? '0 : onehot(g);
            exp_val = m_busy && (c >= m_due);
            vectors++;
            if (req_rdy !== exp_rdy || resp_val !== exp_val) begin
                miscompares++; $display("FAIL rand_c%0d: rdy=%b val=%b want %b %b", c, req_rdy, resp_val, exp_rdy, exp_val);
            end
            if (exp_val && resp_rdy) begin
                exp = exp_q.pop_front();
                got = {resp_id, resp_y};
                vectors++;
                if (got !== exp) begin miscompares++; $display("FAIL rand_resp_c%0d: id_y=%h want %h", c, got, exp); end
                m_busy = 0;
            end else if (!m_busy && g >= 0) begin
                model_accept(g);
                m_busy = 1;
                m_due = c + LAT + 2;
                op_a[g] = 8'($urandom_range(0, 255));
                op_b[g] = 8'($urandom_range(0, 255));
            end
            tick();
        end
        req_val = '0;
        resp_rdy = 1'b1;
        for (int k = 0; k < 8 && m_busy; k++) begin
            if (resp_val) begin
                exp = exp_q.pop_front();
                got = {resp_id, resp_y};
                vectors++;
                if (got !== exp) begin miscompares++; $display("FAIL rand_drain: id_y=%h want %h", got, exp); end
                m_busy = 0;
            end
            tick();
        end
        vectors++;
        if (m_busy || exp_q.size() != 0) begin miscompares++; $display("FAIL rand_drain_timeout: pending=%0d want 0", exp_q.size()); end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        test_reset();
        test_single_op();
        test_round_robin();
        test_wrap();
        test_back_pressure();
        test_latency();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
